// File: rtl/pn_pkg.sv
// Shared constants and LFSR step function for the PN spreading-code generator.
package pn_pkg;

  localparam int PN_LFSR_W   = 10;
  localparam int PN_CODE_LEN = (1 << PN_LFSR_W) - 1;
  localparam int PN_DIV_W    = 8;

  // x^10 + x^3 + 1, all-ones seed
  localparam logic [PN_LFSR_W-1:0] PN_TAPS = 10'h009;
  localparam logic [PN_LFSR_W-1:0] PN_SEED = 10'h3FF;

  function automatic logic [PN_LFSR_W-1:0] lfsr_next(
    input logic [PN_LFSR_W-1:0] lfsr,
    input logic [PN_LFSR_W-1:0] taps
  );
    return {^(lfsr & taps), lfsr[PN_LFSR_W-1:1]};
  endfunction

endpackage

// File: rtl/pn_chip_timer.sv
// Chip-rate divider: a chip lasts div+1 clocks; div is sampled only at chip boundaries.
module pn_chip_timer
  import pn_pkg::*;
#(
  parameter int DIV_W = PN_DIV_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [DIV_W-1:0] div,
  output logic             chip_stb,
  output logic             chip_first
);

  logic [DIV_W-1:0] div_cnt;
  logic [DIV_W-1:0] div_q;
  logic             at_end;

  assign at_end     = (div_cnt == div_q);
  assign chip_stb   = en & at_end;
  assign chip_first = (div_cnt == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt <= '0;
      div_q   <= div;
    end else if (en) begin
      if (at_end) begin
        div_cnt <= '0;
        div_q   <= div;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/pn_code_gen.sv
// Maximal-length PN code generator with programmable chip rate, epoch strobe
// and one-chip code-phase slips for the correlator's code search.
module pn_code_gen
  import pn_pkg::*;
#(
  parameter int                 LFSR_W = PN_LFSR_W,
  parameter logic [LFSR_W-1:0]  TAPS   = PN_TAPS,
  parameter logic [LFSR_W-1:0]  SEED   = PN_SEED,
  parameter int                 DIV_W  = PN_DIV_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [DIV_W-1:0]  div,
  input  logic              slip_req,
  output logic              slip_ack,
  output logic              code,
  output logic              chip_stb,
  output logic              epoch,
  output logic [LFSR_W-1:0] chip_idx,
  output logic [7:0]        epoch_cnt
);

  localparam int CODE_LEN = (1 << LFSR_W) - 1;

  logic [LFSR_W-1:0] lfsr;
  logic              chip_first;
  logic              last_chip;

  pn_chip_timer #(.DIV_W(DIV_W)) u_timer (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .div        (div),
    .chip_stb   (chip_stb),
    .chip_first (chip_first)
  );

  assign code      = lfsr[0];
  assign epoch     = (chip_idx == '0) & chip_first;
  assign slip_ack  = chip_stb & slip_req;
  assign last_chip = (chip_idx == LFSR_W'(CODE_LEN - 1));

  // A slip simply skips one advance, so the current chip repeats for a full period.
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr      <= SEED;
      chip_idx  <= '0;
      epoch_cnt <= '0;
    end else if (chip_stb && !slip_req) begin
      if (last_chip) begin
        lfsr      <= SEED;
        chip_idx  <= '0;
        epoch_cnt <= epoch_cnt + 1'b1;
      end else begin
        lfsr      <= lfsr_next(lfsr, TAPS);
        chip_idx  <= chip_idx + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pn_code_gen.sv
// Self-checking bench for pn_code_gen: table vectors, corner sequences, random run vs model.
module tb_pn_code_gen;
  import pn_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic       slip_req = 1'b0;
  logic [7:0] div = 8'd0;
  logic       slip_ack, code, chip_stb, epoch;
  logic [9:0] chip_idx;
  logic [7:0] epoch_cnt;

  pn_code_gen dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .div       (div),
    .slip_req  (slip_req),
    .slip_ack  (slip_ack),
    .code      (code),
    .chip_stb  (chip_stb),
    .epoch     (epoch),
    .chip_idx  (chip_idx),
    .epoch_cnt (epoch_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference: code sequence from the linear recurrence, timing as chip lengths.
  bit code_tab [PN_CODE_LEN];
  int m_idx, m_pos, m_len, m_ecnt;
  bit m_valid = 1'b0;
  bit m_ack;

  typedef struct {
    int d;
    int n;
    int idx;
    bit cd;
    bit ep;
    int ecnt;
  } vec_t;
  vec_t vt [9];

  int t, c, stbs, ones, acks, chg;
  bit a;
  logic [9:0] s_idx;
  logic       s_code, s_ep;
  logic [7:0] s_ecnt;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void build_tab();
    logic [9:0] sd;
    logic [9:0] tp;
    bit x;
    sd = PN_SEED;
    tp = PN_TAPS;
    for (int n = 0; n < 10; n++) code_tab[n] = sd[n];
    for (int n = 10; n < PN_CODE_LEN; n++) begin
      x = 1'b0;
      for (int k = 0; k < 10; k++) if (tp[k]) x ^= code_tab[n - 10 + k];
      code_tab[n] = x;
    end
  endfunction

  // Check outputs against model for the current inputs, advance model, clock once.
  task automatic step();
    bit e_stb, e_ep;
    #1;
    m_ack = 1'b0;
    if (m_valid) begin
      e_stb = en && (m_pos == m_len - 1);
      m_ack = e_stb && slip_req;
      e_ep  = (m_idx == 0) && (m_pos == 0);
      chk("code", int'(code), int'(code_tab[m_idx]));
      chk("chip_idx", int'(chip_idx), m_idx);
      chk("epoch", int'(epoch), int'(e_ep));
      chk("chip_stb", int'(chip_stb), int'(e_stb));
      chk("slip_ack", int'(slip_ack), int'(m_ack));
      chk("epoch_cnt", int'(epoch_cnt), m_ecnt % 256);
      if (!rst && en) begin
        if (e_stb) begin
          m_pos = 0;
          m_len = int'(div) + 1;
          if (!slip_req) begin
            if (m_idx == PN_CODE_LEN - 1) begin
              m_idx = 0;
              m_ecnt++;
            end else begin
              m_idx++;
            end
          end
        end else begin
          m_pos++;
        end
      end
    end
    if (rst) begin
      m_valid = 1'b1;
      m_idx = 0;
      m_pos = 0;
      m_len = int'(div) + 1;
      m_ecnt = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int d);
    rst = 1'b1;
    div = 8'(d);
    en = 1'b1;
    slip_req = 1'b0;
    step();
    rst = 1'b0;
  endtask

  task automatic slip_test(input int nslip);
    do_reset(3);
    t = 0;
    while (chip_idx != 10'd5 && t < 100) begin step(); t++; end
    slip_req = 1'b1;
    acks = 0;
    c = 0;
    while (chip_idx == 10'd5 && c < 100) begin
      a = slip_ack;
      acks += int'(a);
      c++;
      step();
      t++;
      if (a && acks >= nslip) slip_req = 1'b0;
    end
    chk("slip_acks", acks, nslip);
    chk("slip_chip5_len", c, 4 * (nslip + 1));
    while (!epoch && t < 5000) begin step(); t++; end
    chk("slip_epoch_time", t, 4092 + 4 * nslip);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog expired actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    build_tab();
    vt[0] = '{d: 0, n: 0,    idx: 0,  cd: 1'b1, ep: 1'b1, ecnt: 0};
    vt[1] = '{d: 0, n: 5,    idx: 5,  cd: 1'b1, ep: 1'b0, ecnt: 0};
    vt[2] = '{d: 0, n: 10,   idx: 10, cd: 1'b0, ep: 1'b0, ecnt: 0};
    vt[3] = '{d: 3, n: 4,    idx: 1,  cd: 1'b1, ep: 1'b0, ecnt: 0};
    vt[4] = '{d: 3, n: 42,   idx: 10, cd: 1'b0, ep: 1'b0, ecnt: 0};
    vt[5] = '{d: 0, n: 1023, idx: 0,  cd: 1'b1, ep: 1'b1, ecnt: 1};
    vt[6] = '{d: 1, n: 2046, idx: 0,  cd: 1'b1, ep: 1'b1, ecnt: 1};
    vt[7] = '{d: 3, n: 8184, idx: 0,  cd: 1'b1, ep: 1'b1, ecnt: 2};
    vt[8] = '{d: 3, n: 4093, idx: 0,  cd: 1'b1, ep: 1'b0, ecnt: 1};

    for (int i = 0; i < 9; i++) begin
      do_reset(vt[i].d);
      repeat (vt[i].n) step();
      chk("vec_idx", int'(chip_idx), vt[i].idx);
      chk("vec_code", int'(code), int'(vt[i].cd));
      chk("vec_epoch", int'(epoch), int'(vt[i].ep));
      chk("vec_ecnt", int'(epoch_cnt), vt[i].ecnt);
    end

    // Balance of a maximal-length sequence and clean wrap back to chip 0.
    do_reset(0);
    chk("reset_stb_div0", int'(chip_stb), 1);
    ones = 0;
    repeat (PN_CODE_LEN) begin ones += int'(code); step(); end
    chk("ones_count", ones, 512);
    chk("wrap_epoch", int'(epoch), 1);
    chk("wrap_ecnt", int'(epoch_cnt), 1);

    // Epoch period and strobe density at div=3.
    do_reset(3);
    t = 0;
    stbs = 0;
    do begin stbs += int'(chip_stb); step(); t++; end while (!epoch && t < 5000);
    chk("epoch_period", t, 4092);
    chk("stb_per_epoch", stbs, 1023);

    // div change mid-chip applies only from the next chip.
    do_reset(3);
    step();
    div = 8'd1;
    t = 1;
    while (chip_idx == 10'd0 && t < 50) begin step(); t++; end
    chk("chip0_len_div_change", t, 4);
    t = 0;
    while (chip_idx == 10'd1 && t < 50) begin step(); t++; end
    chk("chip1_len_div_change", t, 2);

    slip_test(1);
    slip_test(2);

    // Slip on the last chip delays the wrap by one chip.
    do_reset(0);
    repeat (PN_CODE_LEN - 1) step();
    slip_req = 1'b1;
    c = 0;
    acks = 0;
    while (chip_idx == 10'd1022 && c < 10) begin
      acks += int'(slip_ack);
      c++;
      step();
      slip_req = 1'b0;
    end
    chip_last_checks: begin
      chk("last_chip_len", c, 2);
      chk("last_chip_acks", acks, 1);
      chk("last_slip_epoch", int'(epoch), 1);
      chk("last_slip_code", int'(code), 1);
      chk("last_slip_ecnt", int'(epoch_cnt), 1);
    end

    // Enable low mid-chip freezes everything; the chip then completes.
    do_reset(3);
    step();
    en = 1'b0;
    s_idx = chip_idx;
    s_code = code;
    s_ep = epoch;
    s_ecnt = epoch_cnt;
    stbs = 0;
    chg = 0;
    repeat (10) begin
      #1;
      stbs += int'(chip_stb) + int'(slip_ack);
      chg += int'(chip_idx != s_idx || code != s_code || epoch != s_ep || epoch_cnt != s_ecnt);
      step();
    end
    chk("frozen_strobes", stbs, 0);
    chk("frozen_changes", chg, 0);
    en = 1'b1;
    c = 0;
    while (chip_idx == 10'd0 && c < 50) begin step(); c++; end
    chk("resume_remaining", c, 3);

    // Reset on the second clock of chip 300 restarts from chip 0.
    do_reset(3);
    t = 0;
    while (chip_idx != 10'd300 && t < 2000) begin step(); t++; end
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_idx", int'(chip_idx), 0);
    chk("midrst_epoch", int'(epoch), 1);
    chk("midrst_code", int'(code), 1);
    repeat (44) step();
    chk("midrst_idx_after", int'(chip_idx), 11);

    // Randomized run against the model, honouring the slip handshake.
    do_reset(2);
    for (int i = 0; i < 6000; i++) begin
      if ($urandom_range(0, 99) < 4) div = 8'($urandom_range(0, 5));
      en = ($urandom_range(0, 9) != 0);
      rst = ($urandom_range(0, 1999) == 0);
      step();
      if (slip_req && m_ack) slip_req = 1'b0;
      else if (!slip_req && $urandom_range(0, 15) == 0) slip_req = 1'b1;
    end
    rst = 1'b0;
    slip_req = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pn_code_gen.md
Name: pn_code_gen

Overview:
- Generates the local spreading code that feeds the `code` input of the downstream correlator.
- Produces a 1023-chip maximal-length LFSR sequence at a programmable chip rate.
- Emits an `epoch` strobe on the first clock of chip 0, used directly as the correlator's epoch restart (its `rst`).
- Supports one-chip code-phase slips via a req/ack handshake, for code-phase search.

Parameters:
- LFSR_W, 10, LFSR width; code length CODE_LEN = 2^LFSR_W - 1 = 1023.
- TAPS, 10'h009, feedback mask. fb = XOR-reduce(lfsr & TAPS). Default gives x^10+x^3+1.
- SEED, 10'h3FF, LFSR load value at reset and at each epoch wrap. Must be non-zero.
- DIV_W, 8, width of the chip-rate divider.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- en  in  1  advance enable. When low, all state is frozen.
- div  in  DIV_W  chip period minus one. A chip lasts div+1 clocks.
- slip_req  in  1  level request to delay the code by one chip.
- slip_ack  out  1  single-cycle acknowledge of a slip.
- code  out  1  current chip value, equal to lfsr[0].
- chip_stb  out  1  high on the last clock of each chip.
- epoch  out  1  high on the first clock of chip 0.
- chip_idx  out  10  index of the current chip, 0..1022.
- epoch_cnt  out  8  number of completed epochs, wraps modulo 256.

Behaviour:
- Reset (rst=1 at a clk edge), state loads:
  - lfsr=SEED, div_cnt=0, div_q=div, chip_idx=0, epoch_cnt=0.
  - Hence code=SEED[0], epoch=1, chip_stb=(div==0), slip_ack=0.
  - rst overrides en and slip_req.
  - Reset mid-chip or mid-slip discards all progress. There is no pending state.
- Outputs are decoded from registered state, with zero added latency:
  - chip_stb = en & (div_cnt==div_q).
  - epoch = (chip_idx==0) & (div_cnt==0).
  - slip_ack = chip_stb & slip_req.
- Divider:
  - With en=1: if div_cnt==div_q, then div_cnt<=0 and div_q<=div. Otherwise div_cnt<=div_cnt+1.
  - A change to div takes effect only from the next chip boundary. The current chip is never truncated.
  - div=0 gives one chip per clock, with chip_stb high continuously.
- Chip boundary (chip_stb=1):
  - If slip_req=1: lfsr and chip_idx hold, so the current chip repeats for one more chip period. slip_ack=1 this cycle.
  - Else if chip_idx==CODE_LEN-1: lfsr<=SEED, chip_idx<=0, epoch_cnt<=epoch_cnt+1.
  - Else: lfsr<={fb, lfsr[9:1]}, chip_idx<=chip_idx+1.
- Slip handshake:
  - The requester holds slip_req until it sees slip_ack, and drops it on the following clock.
  - Each ack corresponds to exactly one slip.
  - If slip_req is still high at the next boundary, another slip is applied. With div=0 this can happen on consecutive clocks, and that is legal.
  - A slip on chip 1022 delays the wrap and the epoch by one chip period.
- Enable: en=0 freezes div_cnt, div_q, lfsr, chip_idx and epoch_cnt. It forces chip_stb=0 and slip_ack=0. code, epoch and chip_idx are held.
- Epoch period: CODE_LEN*(div+1) clocks for a constant div with no slips. Each slip adds div+1 clocks.

Decomposition:
- Package pn_pkg holds:
  - LFSR_W, CODE_LEN and DIV_W defaults.
  - Default TAPS/SEED constants.
  - A function lfsr_next(lfsr, taps) returning {^(lfsr&taps), lfsr[W-1:1]}.
- One natural sub-module: pn_chip_timer, containing div_cnt, div_q and chip_stb.
- LFSR stepping, chip index, epoch logic and the slip handshake stay in the top level.

Test Plan:
- Reset release with div=0, en=1 -> chips 0..9 are all 1, chip 10 is 0, and epoch=1 on the first clock. Exactly 512 ones in chips 0..1022. chip 1023 equals chip 0, with epoch=1 and epoch_cnt=1.
- div=3 -> chip_stb is high one clock in every 4, and epochs are spaced exactly 4092 clocks apart. Change div to 1 mid-chip -> the current chip still lasts 4 clocks and the next lasts 2.
- div=3, slip_req raised during chip 5 -> slip_ack on chip 5's last clock, chip_idx=5 for 8 clocks, and the next epoch arrives 4 clocks late. Holding slip_req for 2 boundaries -> 2 acks and an 8-clock delay.
- Slip at chip 1022, div=0 -> chip 1022 is output for 2 clocks, then epoch=1 with code=SEED[0] and epoch_cnt incremented once.
- en=0 for 10 clocks mid-chip (div=3) -> no chip_stb, all outputs constant. Resume -> the chip completes its remaining clocks.
- rst asserted on clock 2 of chip 300 -> next clock chip_idx=0, epoch=1, div_cnt=0, and the sequence restarts from chip 0.
